// File: rtl/regfile_wr_sched.sv
// rtl/regfile_wr_sched.sv - write-port scheduler for the 32x32 register file (wb > md/io round-robin, r1..r31 clear sweep)
// Optional RFWS_STALL_STATS_EN adds a saturating md/io stall counter output.
module regfile_wr_sched #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              md_valid,
   output logic              md_ready,
   input  logic [ADDR_W-1:0] md_addr,
   input  logic [DATA_W-1:0] md_data,
   input  logic              io_valid,
   output logic              io_ready,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_data,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [1:0]        wr_src
`ifdef RFWS_STALL_STATS_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam logic [0:0] S_RUN   = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_WB   = 2'd1;
   localparam logic [1:0] SRC_MD   = 2'd2;
   localparam logic [1:0] SRC_IO   = 2'd3;

   // rr_ptr names the source that wins the next md/io tie
   localparam logic RR_MD = 1'b0;
   localparam logic RR_IO = 1'b1;

   localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_idx;
   logic              rr_ptr;

   logic              md_grant;
   logic              io_grant;
   logic              clr_issue;

   always_comb begin
      md_grant  = 1'b0;
      io_grant  = 1'b0;
      clr_issue = 1'b0;
      if (!wb_valid) begin
         if (state == S_CLEAR) begin
            clr_issue = 1'b1;
         end else if (md_valid && io_valid) begin
            md_grant = (rr_ptr == RR_MD);
            io_grant = (rr_ptr == RR_IO);
         end else begin
            md_grant = md_valid;
            io_grant = io_valid;
         end
      end
   end

   assign md_ready   = md_grant;
   assign io_ready   = io_grant;
   assign clear_busy = (state == S_CLEAR);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_src  <= SRC_NONE;
      end else begin
         wr_en  <= 1'b0;
         wr_src <= SRC_NONE;
         if (wb_valid) begin
            wr_en   <= (wb_addr != ZERO_ADDR);
            wr_addr <= wb_addr;
            wr_data <= wb_data;
            wr_src  <= SRC_WB;
         end else if (md_grant) begin
            wr_en   <= (md_addr != ZERO_ADDR);
            wr_addr <= md_addr;
            wr_data <= md_data;
            wr_src  <= SRC_MD;
         end else if (io_grant) begin
            wr_en   <= (io_addr != ZERO_ADDR);
            wr_addr <= io_addr;
            wr_data <= io_data;
            wr_src  <= SRC_IO;
         end else if (clr_issue) begin
            wr_en   <= 1'b1;
            wr_addr <= clr_idx;
            wr_data <= '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr <= RR_MD;
      end else if (md_grant) begin
         rr_ptr <= RR_IO;
      end else if (io_grant) begin
         rr_ptr <= RR_MD;
      end
   end

   // A wb write during the sweep steals the port, so clr_idx only advances on clr_issue
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_RUN;
         clr_idx    <= FIRST_IDX;
         clear_done <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         case (state)
            S_RUN: begin
               if (clear_start) begin
                  state   <= S_CLEAR;
                  clr_idx <= FIRST_IDX;
               end
            end
            default: begin
               if (clr_issue) begin
                  if (clr_idx == LAST_IDX) begin
                     state      <= S_RUN;
                     clear_done <= 1'b1;
                  end else begin
                     clr_idx <= clr_idx + ADDR_W'(1);
                  end
               end
            end
         endcase
      end
   end

`ifdef RFWS_STALL_STATS_EN
   logic clr_first;
   logic stall_event;

   assign stall_event = (md_valid & ~md_ready) | (io_valid & ~io_ready);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clr_first <= 1'b0;
         stall_cnt <= '0;
      end else begin
         clr_first <= (state == S_RUN) && clear_start;
         if ((state == S_CLEAR) && clr_first) begin
            stall_cnt <= '0;
         end else if (stall_event && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb/tb_regfile_wr_sched.sv - scoreboard bench for regfile_wr_sched against a queue-based reference model
module tb_regfile_wr_sched;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          wb_valid = 1'b0, md_valid = 1'b0, io_valid = 1'b0, clear_start = 1'b0;
   logic [AW-1:0] wb_addr = '0, md_addr = '0, io_addr = '0;
   logic [DW-1:0] wb_data = '0, md_data = '0, io_data = '0;
   logic          md_ready, io_ready, clear_busy, clear_done, wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [1:0]    wr_src;
`ifdef RFWS_STALL_STATS_EN
   logic [15:0]   stall_cnt;
`endif

   regfile_wr_sched #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
      .io_valid(io_valid), .io_ready(io_ready), .io_addr(io_addr), .io_data(io_data),
      .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
`ifdef RFWS_STALL_STATS_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    src;
      logic          done;
      logic          busy;
   } exp_t;

   exp_t          sb[$];
   int            clr_q[$];
   bit            last_io;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: wb first, then any pending clear address, then md/io alternating on ties
   task automatic model_step(output bit g_md, output bit g_io);
      exp_t e;
      bit   was_run;
      int   a;
      was_run = (clr_q.size() == 0);
      g_md = 0; g_io = 0;
      e.en = 0; e.src = 0; e.done = 0;
      if (wb_valid) begin
         m_addr = wb_addr; m_data = wb_data; e.src = 1; e.en = (wb_addr != 0);
      end else if (clr_q.size() > 0) begin
         a = clr_q.pop_front();
         m_addr = a[AW-1:0]; m_data = 0; e.en = 1; e.done = (clr_q.size() == 0);
      end else if (md_valid && (!io_valid || last_io)) begin
         g_md = 1; last_io = 0;
         m_addr = md_addr; m_data = md_data; e.src = 2; e.en = (md_addr != 0);
      end else if (io_valid) begin
         g_io = 1; last_io = 1;
         m_addr = io_addr; m_data = io_data; e.src = 3; e.en = (io_addr != 0);
      end
      if (was_run && clear_start)
         for (int i = 1; i <= 31; i++) clr_q.push_back(i);
      e.addr = m_addr; e.data = m_data; e.busy = (clr_q.size() > 0);
      sb.push_back(e);
   endtask

   task automatic tick(output bit g_md, output bit g_io);
      @(negedge clock);
      model_step(g_md, g_io);
      chk("md_ready", md_ready, g_md);
      chk("io_ready", io_ready, g_io);
      @(posedge clock);
      #3;
   endtask

   always @(posedge clock) begin
      exp_t e;
      #2;
      if (reset && sb.size() > 0) begin
         e = sb.pop_front();
         chk("wr_en", wr_en, e.en);
         chk("wr_addr", wr_addr, e.addr);
         chk("wr_data", wr_data, e.data);
         chk("wr_src", wr_src, e.src);
         chk("clear_done", clear_done, e.done);
         chk("clear_busy", clear_busy, e.busy);
      end
   end

   task automatic idle_inputs();
      wb_valid = 0; md_valid = 0; io_valid = 0; clear_start = 0;
   endtask

   task automatic apply_reset();
      reset = 0;
      #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_src", wr_src, 0);
      chk("rst_clear_busy", clear_busy, 0);
      chk("rst_clear_done", clear_done, 0);
`ifdef RFWS_STALL_STATS_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      sb.delete(); clr_q.delete();
      last_io = 1; m_addr = 0; m_data = 0;
      idle_inputs();
      repeat (2) @(posedge clock);
      #3;
      reset = 1;
   endtask

   initial begin
      bit gm, gi;
      int busy_cnt, done_cnt, n;
      apply_reset();

      wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
      tick(gm, gi);
      chk("wb_first_src", wr_src, 1);
      chk("wb_first_data", wr_data, 32'hDEADBEEF);
      wb_valid = 0;
      tick(gm, gi);

      wb_valid = 1; md_valid = 1; io_valid = 1;
      md_addr = 7; md_data = 32'h0000_0777; io_addr = 9; io_data = 32'h0000_0999;
      for (int i = 0; i < 3; i++) begin
         wb_addr = AW'(10 + i); wb_data = $urandom;
         tick(gm, gi);
      end
      wb_valid = 0;
      tick(gm, gi);
      chk("rr_first_md", gm, 1);
      md_valid = 0;
      tick(gm, gi);
      chk("rr_then_io", gi, 1);
      io_valid = 0;
      tick(gm, gi);

      md_valid = 1; io_valid = 1;
      for (int i = 0; i < 4; i++) begin
         md_addr = AW'($urandom_range(1, 31)); md_data = $urandom;
         io_addr = AW'($urandom_range(1, 31)); io_data = $urandom;
         tick(gm, gi);
      end
      idle_inputs();
      tick(gm, gi);

      io_valid = 1; io_addr = 0; io_data = 32'h12345678;
      tick(gm, gi);
      chk("io_r0_en", wr_en, 0);
      chk("io_r0_src", wr_src, 3);
      io_valid = 0;
      tick(gm, gi);

      clear_start = 1;
      tick(gm, gi);
      clear_start = 0;
      md_valid = 1; md_addr = 3; md_data = 32'hCAFE0003;
      busy_cnt = int'(clear_busy); done_cnt = 0; n = 0;
      gm = 0;
      while (!gm && n < 40) begin
         tick(gm, gi);
         n++;
         busy_cnt += int'(clear_busy);
         done_cnt += int'(clear_done);
      end
      chk("sweep_md_granted_after", gm, 1);
      chk("sweep_busy_cycles", busy_cnt, 31);
      chk("sweep_done_pulses", done_cnt, 1);
      md_valid = 0;
      tick(gm, gi);

      clear_start = 1;
      tick(gm, gi);
      clear_start = 0;
      for (int i = 0; i < 12; i++) tick(gm, gi);
      chk("midsweep_addr", wr_addr, 12);
      apply_reset();
      clear_start = 1;
      tick(gm, gi);
      clear_start = 0;
      tick(gm, gi);
      chk("restart_addr", wr_addr, 1);
      for (int i = 0; i < 32; i++) tick(gm, gi);

      for (int i = 0; i < 400; i++) begin
         wb_valid = ($urandom_range(0, 3) == 0);
         wb_addr = AW'($urandom_range(0, 31)); wb_data = $urandom;
         if (!md_valid || gm) begin
            md_valid = ($urandom_range(0, 2) != 0);
            md_addr = AW'($urandom_range(0, 31)); md_data = $urandom;
         end
         if (!io_valid || gi) begin
            io_valid = ($urandom_range(0, 2) != 0);
            io_addr = AW'($urandom_range(0, 31)); io_data = $urandom;
         end
         clear_start = ($urandom_range(0, 59) == 0);
         tick(gm, gi);
      end
      idle_inputs();
      for (int i = 0; i < 40; i++) tick(gm, gi);
      @(posedge clock);
      #3;
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
